// File: rtl/intr_ctrl.sv
// Prioritized interrupt controller: edge-latched pending, mask, irq/iack/EOI.
// Optional rotating priority when INTR_ROTATE_PRIO_EN is defined.
module intr_ctrl #(
  parameter int NSRC    = 4,
  parameter int datawid = 16,
  parameter int vecwid  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               wr,
  input  logic               rd,
  input  logic [1:0]         addr,
  input  logic [datawid-1:0] datain,
  output logic [datawid-1:0] dataout,
  input  logic [NSRC-1:0]    src,
  output logic               irq,
  output logic [vecwid-1:0]  vector,
  input  logic               iack
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t              state, state_n;
  logic [NSRC-1:0]     mask, pending, src_d;
  logic [NSRC-1:0]     rise, clr, pend_n, elig;
  logic                insvc, insvc_n, irq_n;
  logic [vecwid-1:0]   vec_n, pick;
  logic                found;
  logic                wr_en, rd_en, iack_ok, eoi_ok;
  logic [datawid-1:0]  rdata;

  assign wr_en   = cs & wr;
  assign rd_en   = cs & rd;
  assign iack_ok = iack && (state == REQ);
  assign eoi_ok  = wr_en && (addr == 2'd3) && (state == SERV);

  assign rise = src & ~src_d;
  assign clr  = ((wr_en && addr == 2'd1) ? datain[NSRC-1:0] : '0)
              | (iack_ok ? (NSRC'(1) << vector) : '0);
  // a fresh edge beats any clear of the same bit
  assign pend_n = (pending & ~clr) | rise;
  assign elig   = pending & mask;

  if (datawid > NSRC) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^datain[datawid-1:NSRC];
  end

`ifdef INTR_ROTATE_PRIO_EN
  logic [vecwid-1:0] ptr;
  logic [vecwid-1:0] pick_lo, pick_hi;
  logic              found_hi;

  // lowest eligible at/above ptr, else wrap to lowest eligible overall
  always_comb begin
    pick_lo  = '0;
    pick_hi  = '0;
    found_hi = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_lo = vecwid'(i);
        if (i >= int'(ptr)) begin
          pick_hi  = vecwid'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick  = found_hi ? pick_hi : pick_lo;
    found = |elig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (iack_ok)
      ptr <= (vector == vecwid'(NSRC - 1)) ? '0 : vector + 1'b1;
  end
`else
  always_comb begin
    pick = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (elig[i]) pick = vecwid'(i);
    found = |elig;
  end
`endif

  always_comb begin
    state_n = state;
    irq_n   = irq;
    vec_n   = vector;
    insvc_n = insvc;
    unique case (state)
      IDLE: if (found) begin
        vec_n   = pick;
        irq_n   = 1'b1;
        state_n = REQ;
      end
      REQ: if (iack_ok) begin
        irq_n   = 1'b0;
        insvc_n = 1'b1;
        state_n = SERV;
      end
      SERV: if (eoi_ok) begin
        insvc_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      2'd0: rdata[NSRC-1:0] = mask;
      2'd1: rdata[NSRC-1:0] = pending;
      2'd2: begin
        rdata[vecwid-1:0]  = vector;
        rdata[datawid-1]   = insvc;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      irq     <= 1'b0;
      vector  <= '0;
      insvc   <= 1'b0;
      mask    <= '0;
      pending <= '0;
      src_d   <= '0;
      dataout <= '0;
    end else begin
      state   <= state_n;
      irq     <= irq_n;
      vector  <= vec_n;
      insvc   <= insvc_n;
      pending <= pend_n;
      src_d   <= src;
      if (wr_en && addr == 2'd0)
        mask <= datain[NSRC-1:0];
      if (rd_en)
        dataout <= rdata;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with hand-computed expectations.
// Expected service order follows INTR_ROTATE_PRIO_EN.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, wr, rd, iack;
  logic [1:0]  addr;
  logic [15:0] datain, dataout;
  logic [3:0]  src, vector;
  logic        irq;
  logic [15:0] rv;

  int n_cmp = 0;
  int n_bad = 0;

  intr_ctrl #(.NSRC(4), .datawid(16), .vecwid(4)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd),
    .addr(addr), .datain(datain), .dataout(dataout),
    .src(src), .irq(irq), .vector(vector), .iack(iack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; datain = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [15:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    d = dataout;
  endtask

  task automatic ack();
    iack = 1'b1;
    tick();
    iack = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] s);
    src = s;
    tick();
    src = 4'h0;
  endtask

  logic [3:0] exp_ord [4];

  initial begin
`ifdef INTR_ROTATE_PRIO_EN
    exp_ord = '{4'd0, 4'd2, 4'd0, 4'd2};
`else
    exp_ord = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif
    rst = 1'b1; cs = 0; wr = 0; rd = 0; iack = 0;
    addr = 0; datain = 0; src = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_irq", irq, 0);
    chk("rst_vec", vector, 0);
    chk("rst_dout", dataout, 0);

    // single source, full handshake
    wr_reg(2'd0, 16'h0001);
    pulse(4'h1);
    chk("t1_irq_early", irq, 0);
    tick();
    chk("t1_irq", irq, 1);
    chk("t1_vec", vector, 0);
    ack();
    chk("t1_irq_ack", irq, 0);
    rd_reg(2'd2, rv);
    chk("t1_stat_serv", rv, 16'h8000);
    wr_reg(2'd3, 16'h0000);
    rd_reg(2'd2, rv);
    chk("t1_stat_eoi", rv, 16'h0000);

    // simultaneous sources, fixed priority
    wr_reg(2'd0, 16'h000F);
    pulse(4'hA);
    tick();
    chk("t2_irq", irq, 1);
    chk("t2_vec1", vector, 1);
    ack();
    wr_reg(2'd3, 16'h0000);
    chk("t2_irq_eoi", irq, 0);
    tick();
    chk("t2_irq_re", irq, 1);
    chk("t2_vec3", vector, 3);
    ack();
    wr_reg(2'd3, 16'h0000);

    // masked pending, late unmask, W1C during REQ
    wr_reg(2'd0, 16'h0000);
    pulse(4'h4);
    repeat (2) tick();
    chk("t3_irq_mask", irq, 0);
    rd_reg(2'd1, rv);
    chk("t3_pend", rv, 16'h0004);
    wr_reg(2'd0, 16'h0004);
    tick();
    chk("t3_irq", irq, 1);
    chk("t3_vec", vector, 2);
    wr_reg(2'd1, 16'h0004);
    tick();
    chk("t3_irq_hold", irq, 1);
    rd_reg(2'd1, rv);
    chk("t3_pend_clr", rv, 16'h0000);
    ack();
    wr_reg(2'd3, 16'h0000);

    // held level sets pending once
    wr_reg(2'd0, 16'h0000);
    src = 4'h1;
    repeat (5) tick();
    wr_reg(2'd1, 16'h0001);
    rd_reg(2'd1, rv);
    chk("t4_level", rv, 16'h0000);
    repeat (4) tick();
    src = 4'h0;
    rd_reg(2'd1, rv);
    chk("t4_level2", rv, 16'h0000);

    // edge on iack cycle survives the clear
    wr_reg(2'd0, 16'h0001);
    pulse(4'h1);
    tick();
    chk("t4_irq", irq, 1);
    iack = 1'b1; src = 4'h1;
    tick();
    iack = 1'b0; src = 4'h0;
    chk("t4_irq_ack", irq, 0);
    rd_reg(2'd1, rv);
    chk("t4_pend_keep", rv, 16'h0001);
    wr_reg(2'd3, 16'h0000);
    tick();
    chk("t4_irq_re", irq, 1);
    ack();

    // reset while in service
    rd_reg(2'd2, rv);
    chk("t5_serv", rv, 16'h8000);
    rst = 1'b1;
    #1;
    chk("t5_irq_rst", irq, 0);
    chk("t5_vec_rst", vector, 0);
    tick();
    rst = 1'b0;
    rd_reg(2'd0, rv);
    chk("t5_mask", rv, 0);
    rd_reg(2'd1, rv);
    chk("t5_pend", rv, 0);
    rd_reg(2'd2, rv);
    chk("t5_stat", rv, 0);
    ack();
    rd_reg(2'd2, rv);
    chk("t5_stray_ack", rv, 0);
    chk("t5_irq", irq, 0);
    rd_reg(2'd3, rv);
    chk("t5_eoi_rd", rv, 0);

    // service order with sources 0 and 2 kept pending
    wr_reg(2'd0, 16'h0005);
    pulse(4'h5);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_irq%0d", k), irq, 1);
      chk($sformatf("t6_vec%0d", k), vector, exp_ord[k]);
      ack();
      pulse(4'h5);
      wr_reg(2'd3, 16'h0000);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
